sd_slv_crc_engine: RTL and testbench

Parametrised multi-lane CRC generator/checker for the SD slave. Covers CRC7 on CMD and CRC16 on DAT[0..LANES-1]. One independent LFSR per lane; a frame controller counts data bits, then serially emits (generate) or compares (check) the CRC bits, MSB first. Sits between the slave's bit-level line shifters and its command/data FSMs.

---
 rtl/sd_slv_crc_engine.sv | 184 ++++++++++++++++++
 tb/tb_sd_slv_crc_engine.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sd_slv_crc_engine.sv
// sd_slv_crc_engine: multi-lane serial CRC generator/checker (CRC7 on CMD, CRC16 on DAT lanes).
// Optional macro SD_CRC_PRESET_EN adds a `preset` input that seeds every LFSR with all-ones.

module sd_slv_crc_lane #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = 7'h09
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] init,
  input  logic             upd,
  input  logic             shift,
  input  logic             cmp,
  input  logic             snap,
  input  logic             gen,
  input  logic             din,
  output logic             dout,
  output logic             err,
  output logic [WIDTH-1:0] crc
);
  logic [WIDTH-1:0] q, q_nxt;

  always_comb begin
    q_nxt = q;
    if (clr)        q_nxt = init;
    else if (upd)   q_nxt = {q[WIDTH-2:0], 1'b0} ^ ((din ^ q[WIDTH-1]) ? POLY : '0);
    else if (shift) q_nxt = {q[WIDTH-2:0], 1'b0};
  end

  // dout is registered from q_nxt so it lines up with the CRC-state cycle it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      crc  <= '0;
      err  <= 1'b0;
      dout <= 1'b0;
    end else begin
      q <= q_nxt;
      if (snap) crc <= q_nxt;
      if (clr)                               err <= 1'b0;
      else if (cmp && (din != q[WIDTH-1]))   err <= 1'b1;
      dout <= gen & q_nxt[WIDTH-1];
    end
  end
endmodule

module sd_slv_crc_engine #(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = 7'h09,
  parameter int               LANES = 1,
  parameter int               LEN_W = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   mode,
  input  logic [LEN_W-1:0]       len,
  input  logic [LANES-1:0]       din,
  input  logic                   din_vld,
`ifdef SD_CRC_PRESET_EN
  input  logic                   preset,
`endif
  output logic [LANES-1:0]       dout,
  output logic                   dout_vld,
  output logic                   busy,
  output logic                   done,
  output logic                   crc_err,
  output logic [LANES-1:0]       err_mask,
  output logic [LANES*WIDTH-1:0] crc
);
  localparam int            CW    = $clog2(WIDTH+1);
  localparam logic [CW-1:0] CLAST = CW'(WIDTH-1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_CRC  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct packed {
    logic             mode;
    logic [LEN_W-1:0] len;
  } frm_t;

  frm_t                         frm;
  logic [1:0]                   state, state_nxt;
  logic [LEN_W-1:0]             cnt;
  logic [CW-1:0]                ccnt;
  logic                         clr, upd, shift, cmp, snap, gen_nxt, mode_eff;
  logic [WIDTH-1:0]             init;
  logic [LANES-1:0][WIDTH-1:0]  crc_a;

`ifdef SD_CRC_PRESET_EN
  assign init = preset ? '1 : '0;
`else
  assign init = '0;
`endif

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    upd       = 1'b0;
    shift     = 1'b0;
    cmp       = 1'b0;
    snap      = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        clr = 1'b1;
        if (len == '0) begin
          snap      = 1'b1;
          state_nxt = S_CRC;
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_DATA: if (din_vld) begin
        upd = 1'b1;
        if ((cnt + 1'b1) == frm.len) begin
          snap      = 1'b1;
          state_nxt = S_CRC;
        end
      end
      S_CRC: begin
        // generate mode free-runs; check mode only advances on qualified bits
        if (!frm.mode || din_vld) begin
          shift = 1'b1;
          cmp   = frm.mode;
          if (ccnt == CLAST) state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mode_eff = (state == S_IDLE) ? mode : frm.mode;
  assign gen_nxt  = (state_nxt == S_CRC) && !mode_eff;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      frm      <= '0;
      cnt      <= '0;
      ccnt     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        frm.mode <= mode;
        frm.len  <= len;
        cnt      <= '0;
        ccnt     <= '0;
      end else begin
        if (upd)   cnt  <= cnt + 1'b1;
        if (shift) ccnt <= ccnt + 1'b1;
      end
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);
      dout_vld <= gen_nxt;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    sd_slv_crc_lane #(.WIDTH(WIDTH), .POLY(POLY)) u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .init  (init),
      .upd   (upd),
      .shift (shift),
      .cmp   (cmp),
      .snap  (snap),
      .gen   (gen_nxt),
      .din   (din[l]),
      .dout  (dout[l]),
      .err   (err_mask[l]),
      .crc   (crc_a[l])
    );
  end

  assign crc     = crc_a;
  assign crc_err = |err_mask;
endmodule

// File: tb/tb_sd_slv_crc_engine.sv
// Directed bench for sd_slv_crc_engine: a CMD (CRC7, 1 lane) and a DAT (CRC16, 4 lanes) instance.
module tb_sd_slv_crc_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        c_start = 1'b0, c_mode = 1'b0, c_din = 1'b0, c_vld = 1'b0;
  logic [12:0] c_len = '0;
  logic        c_dout, c_dout_vld, c_busy, c_done, c_err, c_mask;
  logic [6:0]  c_crc;

  logic        d_start = 1'b0, d_mode = 1'b0, d_vld = 1'b0;
  logic [3:0]  d_din = '0;
  logic [12:0] d_len = '0;
  logic [3:0]  d_dout, d_mask;
  logic        d_dout_vld, d_busy, d_done, d_err;
  logic [63:0] d_crc;
`ifdef SD_CRC_PRESET_EN
  logic        c_preset = 1'b0, d_preset = 1'b0;
`endif

  sd_slv_crc_engine #(.WIDTH(7), .POLY(7'h09), .LANES(1), .LEN_W(13)) u_cmd (
    .clk(clk), .rst(rst), .start(c_start), .mode(c_mode), .len(c_len),
    .din(c_din), .din_vld(c_vld),
`ifdef SD_CRC_PRESET_EN
    .preset(c_preset),
`endif
    .dout(c_dout), .dout_vld(c_dout_vld), .busy(c_busy), .done(c_done),
    .crc_err(c_err), .err_mask(c_mask), .crc(c_crc)
  );

  sd_slv_crc_engine #(.WIDTH(16), .POLY(16'h1021), .LANES(4), .LEN_W(13)) u_dat (
    .clk(clk), .rst(rst), .start(d_start), .mode(d_mode), .len(d_len),
    .din(d_din), .din_vld(d_vld),
`ifdef SD_CRC_PRESET_EN
    .preset(d_preset),
`endif
    .dout(d_dout), .dout_vld(d_dout_vld), .busy(d_busy), .done(d_done),
    .crc_err(d_err), .err_mask(d_mask), .crc(d_crc)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One CMD frame starting in the next cycle (cycle 0 = start); returns on the done cycle.
  task automatic run_cmd(input string tag, input logic md, input int len, input logic [39:0] data,
                         input logic [6:0] ck, input bit gaps, input int kick,
                         output logic [6:0] seq, output int ndo, output int dc);
    int bi, cyc, nbits;
    bi = 0; seq = '0; ndo = 0; dc = -1;
    nbits = len + (md ? 7 : 0);
    @(posedge clk); #1;
    chk({tag, "_idle"}, c_busy, 0);
    c_start = 1'b1; c_mode = md; c_len = 13'(len); c_vld = 1'b0;
    cyc = 0;
    for (int t = 0; t < 500; t++) begin
      @(posedge clk); #1; cyc++;
      c_start = (cyc == kick);
      if (cyc == 1) chk({tag, "_busy1"}, c_busy, 1);
      if (c_dout_vld) begin seq = {seq[5:0], c_dout}; ndo++; end
      if (c_done) begin dc = cyc; break; end
      if (bi < nbits) begin
        c_vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        c_din = (bi < len) ? data[len-1-bi] : ck[6-(bi-len)];
        if (c_vld) bi++;
      end else c_vld = 1'b0;
    end
    c_vld = 1'b0; c_start = 1'b0;
    if (dc < 0) begin checks++; errors++; $error("FAIL %s_timeout: no done seen", tag); end
  endtask

  // One DAT frame of all-ones data; check mode sends 16'h7FA1 with the last bit of `flip` lanes inverted.
  task automatic run_dat(input string tag, input logic md, input int len, input logic [3:0] flip,
                         input bit gaps, output logic [15:0] seq0, output int ndo, output int dc,
                         output int mixed);
    int bi, cyc, nbits;
    logic [15:0] ref_crc;
    ref_crc = 16'h7FA1;
    bi = 0; seq0 = '0; ndo = 0; dc = -1; mixed = 0;
    nbits = len + (md ? 16 : 0);
    @(posedge clk); #1;
    chk({tag, "_idle"}, d_busy, 0);
    d_start = 1'b1; d_mode = md; d_len = 13'(len); d_vld = 1'b0;
    cyc = 0;
    for (int t = 0; t < 10000; t++) begin
      @(posedge clk); #1; cyc++;
      d_start = 1'b0;
      if (d_dout_vld) begin
        seq0 = {seq0[14:0], d_dout[0]}; ndo++;
        if (d_dout != 4'h0 && d_dout != 4'hF) mixed++;
      end
      if (d_done) begin dc = cyc; break; end
      if (bi < nbits) begin
        d_vld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bi < len) d_din = 4'hF;
        else          d_din = {4{ref_crc[15-(bi-len)]}} ^ ((bi == nbits-1) ? flip : 4'h0);
        if (d_vld) bi++;
      end else d_vld = 1'b0;
    end
    d_vld = 1'b0;
    if (dc < 0) begin checks++; errors++; $error("FAIL %s_timeout: no done seen", tag); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [6:0]  seq;
    logic [15:0] seq16;
    int ndo, dc, mixed;

    repeat (3) @(posedge clk); #1;
    chk("rst_busy", c_busy, 0);
    chk("rst_done", c_done, 0);
    chk("rst_dout_vld", c_dout_vld, 0);
    chk("rst_dout", c_dout, 0);
    chk("rst_crc", c_crc, 0);
    chk("rst_crc_err", c_err, 0);
    chk("rst_dat_crc", d_crc, 0);
    chk("rst_dat_mask", d_mask, 0);
    rst = 1'b0;

    // CMD0: CRC7 = 0x4A, serial 1001010, done 48 cycles after start
    run_cmd("cmd0_gen", 1'b0, 40, 40'h40_0000_0000, 7'h00, 0, 0, seq, ndo, dc);
    chk("cmd0_crc", c_crc, 7'h4A);
    chk("cmd0_dout", seq, 7'b1001010);
    chk("cmd0_ndout", ndo, 7);
    chk("cmd0_done_cyc", dc, 48);
    chk("cmd0_err", c_err, 0);

    run_cmd("cmd8_chk", 1'b1, 40, 40'h48_0000_01AA, 7'h43, 0, 0, seq, ndo, dc);
    chk("cmd8_crc", c_crc, 7'h43);
    chk("cmd8_err", c_err, 0);
    chk("cmd8_mask", c_mask, 0);
    chk("cmd8_no_dout", ndo, 0);
    chk("cmd8_done_cyc", dc, 48);

    run_cmd("cmd8_bad", 1'b1, 40, 40'h48_0000_01AA, 7'h42, 0, 0, seq, ndo, dc);
    chk("cmd8_bad_err", c_err, 1);
    chk("cmd8_bad_mask", c_mask, 1);
    @(posedge clk); #1;
    chk("cmd8_bad_err_held", c_err, 1);

    run_cmd("cmd17_gaps", 1'b0, 40, 40'h51_0000_0000, 7'h00, 1, 0, seq, ndo, dc);
    chk("cmd17_crc", c_crc, 7'h2A);
    chk("cmd17_dout", seq, 7'h2A);
    chk("cmd17_err_cleared", c_err, 0);

    run_cmd("cmd8_gaps", 1'b1, 40, 40'h48_0000_01AA, 7'h43, 1, 0, seq, ndo, dc);
    chk("cmd8_gaps_crc", c_crc, 7'h43);
    chk("cmd8_gaps_err", c_err, 0);

    // start pulsed mid-frame must not restart anything
    run_cmd("cmd0_kick", 1'b0, 40, 40'h40_0000_0000, 7'h00, 0, 20, seq, ndo, dc);
    chk("kick_done_cyc", dc, 48);
    chk("kick_crc", c_crc, 7'h4A);

    run_cmd("len0", 1'b0, 0, 40'h0, 7'h00, 0, 0, seq, ndo, dc);
    chk("len0_crc", c_crc, 0);
    chk("len0_dout", seq, 0);
    chk("len0_ndout", ndo, 7);
    chk("len0_done_cyc", dc, 8);

    run_cmd("cmd0_again", 1'b0, 40, 40'h40_0000_0000, 7'h00, 0, 0, seq, ndo, dc);
    // reset in the middle of DATA
    @(posedge clk); #1;
    c_start = 1'b1; c_mode = 1'b0; c_len = 13'd40;
    @(posedge clk); #1;
    c_start = 1'b0; c_vld = 1'b1; c_din = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_busy", c_busy, 1);
    chk("mid_crc_held", c_crc, 7'h4A);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; c_vld = 1'b0;
    chk("rst_mid_busy", c_busy, 0);
    chk("rst_mid_crc", c_crc, 0);
    chk("rst_mid_dout_vld", c_dout_vld, 0);

    run_cmd("cmd55", 1'b0, 40, 40'h77_0000_0000, 7'h00, 0, 0, seq, ndo, dc);
    chk("cmd55_crc", c_crc, 7'h32);
    chk("cmd55_dout", seq, 7'h32);
    chk("cmd55_done_cyc", dc, 48);

    // DAT: 4096 ones per lane -> CRC16 0x7FA1 on every lane
    run_dat("dat_gen", 1'b0, 4096, 4'h0, 0, seq16, ndo, dc, mixed);
    chk("dat_crc", d_crc, {4{16'h7FA1}});
    chk("dat_dout0", seq16, 16'h7FA1);
    chk("dat_ndout", ndo, 16);
    chk("dat_lanes_agree", mixed, 0);
    chk("dat_done_cyc", dc, 4113);

    run_dat("dat_lane2_bad", 1'b1, 4096, 4'b0100, 0, seq16, ndo, dc, mixed);
    chk("dat_bad_mask", d_mask, 4'b0100);
    chk("dat_bad_err", d_err, 1);

    run_dat("dat_chk_gaps", 1'b1, 4096, 4'b0000, 1, seq16, ndo, dc, mixed);
    chk("dat_gaps_crc", d_crc, {4{16'h7FA1}});
    chk("dat_gaps_mask", d_mask, 0);
    chk("dat_gaps_err", d_err, 0);

    run_dat("dat_len0", 1'b0, 0, 4'h0, 0, seq16, ndo, dc, mixed);
    chk("dat_len0_crc", d_crc, 0);
    chk("dat_len0_done_cyc", dc, 17);

`ifdef SD_CRC_PRESET_EN
    c_preset = 1'b1;
    run_cmd("cmd_preset", 1'b0, 0, 40'h0, 7'h00, 0, 0, seq, ndo, dc);
    c_preset = 1'b0;
    chk("preset_crc", c_crc, 7'h7F);
    chk("preset_dout", seq, 7'h7F);
    chk("preset_ndout", ndo, 7);
    d_preset = 1'b1;
    run_dat("dat_preset", 1'b0, 0, 4'h0, 0, seq16, ndo, dc, mixed);
    d_preset = 1'b0;
    chk("dat_preset_crc", d_crc, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dat_preset_dout", seq16, 16'hFFFF);
`endif

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
